// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multiply-accumulate engine.
// sat_shift rounds, shifts and clamps a sign- or zero-extended accumulator.
package mac_pkg;

  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;

  // Working width of the saturation arithmetic; accumulators must be narrower.
  localparam int SAT_MAXW = 128;

  typedef struct packed {
    logic                sat;
    logic [SAT_MAXW-1:0] data;
  } sat_res_t;

  function automatic int acc_width(input int bit_w, input int guard);
    return 2 * bit_w + guard;
  endfunction

  function automatic sat_res_t sat_shift(
    input logic [SAT_MAXW-1:0] acc,
    input logic                sgn,
    input int                  out_w,
    input int                  shift,
    input logic                rnd
  );
    logic signed [SAT_MAXW:0] v;
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    sat_res_t                 res;
    one = {{SAT_MAXW{1'b0}}, 1'b1};
    v   = {sgn & acc[SAT_MAXW-1], acc};
    if (rnd && shift > 0) begin
      v = v + (one <<< (shift - 1));
    end
    v = v >>> shift;
    if (sgn) begin
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
    end else begin
      hi = (one <<< out_w) - one;
      lo = '0;
    end
    res.sat  = 1'b0;
    res.data = v[SAT_MAXW-1:0];
    if (v > hi) begin
      res.sat  = 1'b1;
      res.data = hi[SAT_MAXW-1:0];
    end else if (v < lo) begin
      res.sat  = 1'b1;
      res.data = lo[SAT_MAXW-1:0];
    end
    return res;
  endfunction

  function automatic logic [SAT_MAXW-1:0] sat_data(
    input logic [SAT_MAXW-1:0] acc,
    input logic                sgn,
    input int                  out_w,
    input int                  shift,
    input logic                rnd
  );
    sat_res_t r;
    r = sat_shift(acc, sgn, out_w, shift, rnd);
    return r.data;
  endfunction

  function automatic logic sat_flag(
    input logic [SAT_MAXW-1:0] acc,
    input logic                sgn,
    input int                  out_w,
    input int                  shift,
    input logic                rnd
  );
    sat_res_t r;
    r = sat_shift(acc, sgn, out_w, shift, rnd);
    return r.sat;
  endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// PIPE-stage BIT x BIT multiplier with stall enable; valid, first, last and
// mode ride alongside the product so they leave the pipe together.
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter int BIT  = 32,
  parameter int PIPE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [BIT-1:0]   i_a,
  input  logic [BIT-1:0]   i_b,
  input  logic             i_mode,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_valid,
  output logic [2*BIT-1:0] o_prod,
  output logic             o_mode,
  output logic             o_first,
  output logic             o_last
);

  typedef struct packed {
    logic             valid;
    logic             mode;
    logic             first;
    logic             last;
    logic [2*BIT-1:0] prod;
  } stage_t;

  stage_t           r_stage [PIPE];
  stage_t           w_in;
  logic [2*BIT-1:0] w_ax;
  logic [2*BIT-1:0] w_bx;

  // Extending by mode first lets one unsigned multiplier serve both modes:
  // the low 2*BIT bits of the product are correct either way.
  assign w_ax = {{BIT{(i_mode == MODE_SIGNED) & i_a[BIT-1]}}, i_a};
  assign w_bx = {{BIT{(i_mode == MODE_SIGNED) & i_b[BIT-1]}}, i_b};

  always_comb begin
    w_in       = '0;
    w_in.valid = i_valid;
    w_in.mode  = i_mode;
    w_in.first = i_first;
    w_in.last  = i_last;
    w_in.prod  = w_ax * w_bx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= w_in;
      for (int i = 1; i < PIPE; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[PIPE-1].valid;
  assign o_prod  = r_stage[PIPE-1].prod;
  assign o_mode  = r_stage[PIPE-1].mode;
  assign o_first = r_stage[PIPE-1].first;
  assign o_last  = r_stage[PIPE-1].last;

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate engine: frame accumulation, rounding shift,
// saturation to OUT_W and a single global stall driven by the output side.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int BIT   = 32,
  parameter int PIPE  = 2,
  parameter int GUARD = 8,
  parameter int OUT_W = 2 * BIT,
  parameter int SHIFT = 0,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIT-1:0]   in_a,
  input  logic [BIT-1:0]   in_b,
  input  logic             in_signed,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [15:0]      out_cnt
);

  localparam int ACC_W = acc_width(BIT, GUARD);

  logic                r_mode;
  logic                w_mode;
  logic                w_en;
  logic                w_accept;

  logic                w_m_valid;
  logic [2*BIT-1:0]    w_m_prod;
  logic                w_m_mode;
  logic                w_m_first;
  logic                w_m_last;
  logic [ACC_W-1:0]    w_prod_ext;

  logic [ACC_W-1:0]    r_acc;
  logic [15:0]         r_cnt;
  logic                r_acc_mode;
  logic                r_emit;
  logic [SAT_MAXW-1:0] w_acc_ext;

  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_sat;
  logic [15:0]         r_out_cnt;

  assign in_ready = !r_out_valid || out_ready;
  assign w_en     = in_ready;
  assign w_accept = in_valid && in_ready;

  // Mode is captured on the first beat and reused for the rest of the frame.
  assign w_mode = in_first ? in_signed : r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_SIGNED;
    end else if (w_accept && in_first) begin
      r_mode <= in_signed;
    end
  end

  mac_mul_pipe #(
    .BIT  (BIT),
    .PIPE (PIPE)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_en),
    .i_valid (w_accept),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_mode  (w_mode),
    .i_first (in_first),
    .i_last  (in_last),
    .o_valid (w_m_valid),
    .o_prod  (w_m_prod),
    .o_mode  (w_m_mode),
    .o_first (w_m_first),
    .o_last  (w_m_last)
  );

  assign w_prod_ext = {{GUARD{(w_m_mode == MODE_SIGNED) & w_m_prod[2*BIT-1]}}, w_m_prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_acc_mode <= MODE_SIGNED;
      r_emit     <= 1'b0;
    end else if (w_en) begin
      r_emit <= w_m_valid && w_m_last;
      if (w_m_valid) begin
        r_acc_mode <= w_m_mode;
        if (w_m_first) begin
          r_acc <= w_prod_ext;
          r_cnt <= 16'd1;
        end else begin
          r_acc <= r_acc + w_prod_ext;
          r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end
      end
    end
  end

  assign w_acc_ext = {{(SAT_MAXW-ACC_W){(r_acc_mode == MODE_SIGNED) & r_acc[ACC_W-1]}}, r_acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_cnt   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_emit;
      if (r_emit) begin
        r_out_data <= OUT_W'(sat_data(w_acc_ext, r_acc_mode, OUT_W, SHIFT, ROUND != 0));
        r_out_sat  <= sat_flag(w_acc_ext, r_acc_mode, OUT_W, SHIFT, ROUND != 0);
        r_out_cnt  <= r_cnt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: four instances cover the main, saturating,
// rounding and truncating configurations; a monitor scores results from queues.
module tb_mac_pipe;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  sel;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic        in_first;
  logic        in_last;
  logic        out_ready;

  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0]  sat;
  logic [31:0] d0, d2, d3;
  logic [15:0] d1;
  logic [15:0] c0, c1, c2, c3;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   first_vld0 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_vld
    assign vld[gi] = in_valid && (sel == 2'(gi));
  end

  mac_pipe #(.BIT(16), .PIPE(2), .GUARD(8), .OUT_W(32), .SHIFT(0), .ROUND(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(d0), .out_sat(sat[0]), .out_cnt(c0));
  mac_pipe #(.BIT(16), .PIPE(2), .GUARD(8), .OUT_W(16), .SHIFT(0), .ROUND(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(d1), .out_sat(sat[1]), .out_cnt(c1));
  mac_pipe #(.BIT(16), .PIPE(2), .GUARD(8), .OUT_W(32), .SHIFT(4), .ROUND(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(d2), .out_sat(sat[2]), .out_cnt(c2));
  mac_pipe #(.BIT(16), .PIPE(2), .GUARD(8), .OUT_W(32), .SHIFT(4), .ROUND(0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last), .out_valid(ov[3]),
    .out_ready(out_ready), .out_data(d3), .out_sat(sat[3]), .out_cnt(c3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic expect_res(input int k, input logic [31:0] data, input logic s,
                            input logic [15:0] cnt);
    exp_t e;
    e.data = data;
    e.sat  = s;
    e.cnt  = cnt;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int k, input logic [31:0] d, input logic s, input logic [15:0] c);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_errors++;
      $display("FAIL dut%0d unexpected output: got data 0x%08h cnt %0d, required none", k, d, c);
    end else begin
      chk($sformatf("dut%0d data", k), d, e.data);
      chk($sformatf("dut%0d sat", k), {31'b0, s}, {31'b0, e.sat});
      chk($sformatf("dut%0d cnt", k), {16'b0, c}, {16'b0, e.cnt});
    end
  endtask

  // Monitor: a result is scored on the cycle it is handed over.
  always @(negedge clk) begin
    if (ov[0] && first_vld0 < 0) first_vld0 = cyc;
    if (!rst && out_ready) begin
      if (ov[0]) pop_chk(0, d0, sat[0], c0);
      if (ov[1]) pop_chk(1, {16'b0, d1}, sat[1], c1);
      if (ov[2]) pop_chk(2, d2, sat[2], c2);
      if (ov[3]) pop_chk(3, d3, sat[3], c3);
    end
  end

  task automatic beat(input int k, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic f, input logic l);
    int g;
    g = 0;
    @(negedge clk);
    sel       = k[1:0];
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_first  = f;
    in_last   = l;
    in_valid  = 1'b1;
    while (!rdy[k] && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!rdy[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL dut%0d accept: in_ready stayed 0, required 1", k);
    end
    last_acc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain pending", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1;
    int prev;
    int g;
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    chk("reset out_valid", {28'b0, ov}, 32'd0);
    chk("reset out_data", d0, 32'd0);
    chk("reset out_sat", {28'b0, sat}, 32'd0);
    chk("reset out_cnt", {16'b0, c0}, 32'd0);
    chk("reset in_ready", {28'b0, rdy}, 32'hF);

    // Single signed beat and pipeline latency.
    expect_res(0, 32'hFFFFFFF1, 1'b0, 16'd1);
    beat(0, 16'hFFFD, 16'd5, 1'b1, 1'b1, 1'b1);
    t1 = last_acc;
    drain();
    chk("latency", 32'(first_vld0 - t1), 32'd4);

    // Unsigned vs signed on the same operands, then mode latched by first beat.
    expect_res(0, 32'hFFFE0001, 1'b0, 16'd1);
    beat(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    expect_res(0, 32'h00000001, 1'b0, 16'd1);
    beat(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    expect_res(0, 32'h0001FFFE, 1'b0, 16'd2);
    beat(0, 16'hFFFF, 16'd1, 1'b0, 1'b1, 1'b0);
    beat(0, 16'hFFFF, 16'd1, 1'b1, 1'b0, 1'b1);

    // Four-beat frame followed back-to-back by a one-beat frame.
    expect_res(0, 32'd40000, 1'b0, 16'd4);
    expect_res(0, 32'hFFFFFFF2, 1'b0, 16'd1);
    beat(0, 16'd100, 16'd100, 1'b1, 1'b1, 1'b0);
    prev = last_acc;
    for (int i = 1; i < 5; i++) begin
      if (i < 4) beat(0, 16'd100, 16'd100, 1'b1, 1'b0, i == 3);
      else       beat(0, 16'd2, 16'hFFF9, 1'b1, 1'b1, 1'b1);
      chk($sformatf("no bubble beat %0d", i), 32'(last_acc - prev), 32'd1);
      prev = last_acc;
    end

    // A first beat inside an open frame restarts it.
    expect_res(0, 32'd4, 1'b0, 16'd1);
    beat(0, 16'd9, 16'd9, 1'b1, 1'b1, 1'b0);
    beat(0, 16'd2, 16'd2, 1'b1, 1'b1, 1'b1);
    drain();

    // Saturation to 16 bits.
    expect_res(1, 32'h00007FFF, 1'b1, 16'd1);
    beat(1, 16'd200, 16'd200, 1'b1, 1'b1, 1'b1);
    expect_res(1, 32'h00008000, 1'b1, 16'd1);
    beat(1, 16'hFF38, 16'd200, 1'b1, 1'b1, 1'b1);
    expect_res(1, 32'h0000FFFF, 1'b1, 16'd1);
    beat(1, 16'd300, 16'd300, 1'b0, 1'b1, 1'b1);
    expect_res(1, 32'h00002710, 1'b0, 16'd1);
    beat(1, 16'd100, 16'd100, 1'b1, 1'b1, 1'b1);

    // Shift by 4 with rounding and with truncation.
    expect_res(2, 32'd1, 1'b0, 16'd1);
    beat(2, 16'd3, 16'd3, 1'b1, 1'b1, 1'b1);
    expect_res(2, 32'd0, 1'b0, 16'd1);
    beat(2, 16'd7, 16'd1, 1'b1, 1'b1, 1'b1);
    expect_res(2, 32'hFFFFFFFF, 1'b0, 16'd1);
    beat(2, 16'hFFF7, 16'd1, 1'b1, 1'b1, 1'b1);
    expect_res(2, 32'd2, 1'b0, 16'd1);
    beat(2, 16'd24, 16'd1, 1'b1, 1'b1, 1'b1);
    expect_res(3, 32'd0, 1'b0, 16'd1);
    beat(3, 16'd3, 16'd3, 1'b1, 1'b1, 1'b1);
    expect_res(3, 32'd1, 1'b0, 16'd1);
    beat(3, 16'd24, 16'd1, 1'b1, 1'b1, 1'b1);
    expect_res(3, 32'hFFFFFFFF, 1'b0, 16'd1);
    beat(3, 16'hFFF7, 16'd1, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: three frames queued behind a stalled consumer.
    @(posedge clk);
    #1 out_ready = 1'b0;
    expect_res(0, 32'd1, 1'b0, 16'd1);
    expect_res(0, 32'd26, 1'b0, 16'd2);
    expect_res(0, 32'hFFFFFFFF, 1'b0, 16'd1);
    beat(0, 16'd1, 16'd1, 1'b1, 1'b1, 1'b1);
    beat(0, 16'd2, 16'd3, 1'b1, 1'b1, 1'b0);
    beat(0, 16'd4, 16'd5, 1'b1, 1'b0, 1'b1);
    beat(0, 16'hFFFF, 16'd1, 1'b1, 1'b1, 1'b1);
    g = 0;
    while (!ov[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall in_ready c%0d", i), {31'b0, rdy[0]}, 32'd0);
      chk($sformatf("stall out_data c%0d", i), d0, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset mid-frame discards the in-flight frame and restores signed mode.
    beat(0, 16'd5, 16'd5, 1'b0, 1'b1, 1'b0);
    beat(0, 16'd6, 16'd6, 1'b0, 1'b0, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    expect_res(0, 32'hFFFFFFF7, 1'b0, 16'd1);
    beat(0, 16'hFFFD, 16'd3, 1'b0, 1'b0, 1'b1);
    expect_res(0, 32'd42, 1'b0, 16'd1);
    beat(0, 16'd6, 16'd7, 1'b1, 1'b1, 1'b1);
    drain();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
